// File: rtl/integrator_rr_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : integrator_rr_scheduler
//  Description : Time-shares a single W-bit integrator adder among NCH
//                requesting channels. Each channel owns an accumulator in a
//                small register bank. Requests are served round-robin through
//                per-channel valid/ready handshakes. Every update is emitted
//                on one backpressured result port, tagged with its channel.
//
//  Ports       :
//    system1000        clock
//    system1000_rstn   synchronous active-low reset
//    req_valid[NCH]    per-channel sample valid
//    req_data[NCH*W]   packed signed samples, channel i at [i*W +: W]
//    req_ready[NCH]    per-channel accept (one-hot or zero)
//    clr[NCH]          per-channel accumulator clear pulse
//    out_valid         result valid
//    out_ch[CW]        channel index of the result
//    out_data[W]       signed accumulator value after the update
//    out_ready         downstream accept
//
//  Revision    : 1.0 - initial release
// ============================================================================
module integrator_rr_scheduler #(
    parameter int NCH = 4,
    parameter int W   = 10,
    parameter int CW  = 2
) (
    input  logic                 system1000,
    input  logic                 system1000_rstn,
    input  logic [NCH-1:0]       req_valid,
    input  logic [NCH*W-1:0]     req_data,
    output logic [NCH-1:0]       req_ready,
    input  logic [NCH-1:0]       clr,
    output logic                 out_valid,
    output logic [CW-1:0]        out_ch,
    output logic signed [W-1:0]  out_data,
    input  logic                 out_ready
);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [CW-1:0]        ptr_q,       ptr_d;
    logic signed [W-1:0]  acc_q [NCH];
    logic signed [W-1:0]  acc_d [NCH];
    logic                 out_valid_q, out_valid_d;
    logic [CW-1:0]        out_ch_q,    out_ch_d;
    logic signed [W-1:0]  out_data_q,  out_data_d;

    // ------------------------------------------------------------------
    // Combinational datapath signals
    // ------------------------------------------------------------------
    logic signed [W-1:0]  sample [NCH];
    logic                 free;
    logic                 grant_found;
    logic [CW-1:0]        grant_idx;
    logic [CW:0]          cand;
    logic                 accept;
    logic signed [W-1:0]  base;
    logic signed [W-1:0]  sum;
    logic [CW-1:0]        ptr_inc;

    // Unpack the flat sample bus into one signed word per channel.
    for (genvar gi = 0; gi < NCH; gi++) begin : g_unpack
        assign sample[gi] = req_data[gi*W +: W];
    end

    // The output register can take a new result when it is empty or is
    // being drained in this same cycle.
    assign free = !out_valid_q || out_ready;

    // ------------------------------------------------------------------
    // Round-robin search starting at ptr_q. cand is one bit wider than the
    // channel index so the modulo-NCH wrap also works for non power-of-two
    // channel counts.
    // ------------------------------------------------------------------
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        cand        = '0;
        for (int k = 0; k < NCH; k++) begin
            cand = {1'b0, ptr_q} + (CW+1)'(k);
            if (cand >= (CW+1)'(NCH)) begin
                cand = cand - (CW+1)'(NCH);
            end
            if (!grant_found && req_valid[cand[CW-1:0]]) begin
                grant_found = 1'b1;
                grant_idx   = cand[CW-1:0];
            end
        end
    end

    // Arbitration is gated by reset so req_ready stays low while in reset.
    assign accept    = system1000_rstn && free && grant_found;
    assign req_ready = accept ? (NCH'(1) << grant_idx) : '0;

    // A clear coinciding with an accept on the same channel zeroes the base
    // so the new sum restarts from the sample. Addition wraps at W bits.
    assign base = clr[grant_idx] ? '0 : acc_q[grant_idx];
    assign sum  = base + sample[grant_idx];

    assign ptr_inc = (grant_idx == CW'(NCH-1)) ? '0 : grant_idx + CW'(1);

    // ------------------------------------------------------------------
    // Next-state logic: output register and pointer
    // ------------------------------------------------------------------
    always_comb begin
        ptr_d       = ptr_q;
        out_valid_d = out_valid_q;
        out_ch_d    = out_ch_q;
        out_data_d  = out_data_q;
        if (accept) begin
            ptr_d       = ptr_inc;
            out_valid_d = 1'b1;
            out_ch_d    = grant_idx;
            out_data_d  = sum;
        end else if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic: accumulator bank. An accept writes the new sum
    // (which already accounts for a simultaneous clear); any other channel
    // with a clear pulse returns to zero.
    // ------------------------------------------------------------------
    always_comb begin
        for (int j = 0; j < NCH; j++) begin
            acc_d[j] = acc_q[j];
            if (accept && (grant_idx == CW'(j))) begin
                acc_d[j] = sum;
            end else if (clr[j]) begin
                acc_d[j] = '0;
            end
        end
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge system1000) begin
        if (!system1000_rstn) begin
            ptr_q       <= '0;
            out_valid_q <= 1'b0;
            out_ch_q    <= '0;
            out_data_q  <= '0;
            for (int j = 0; j < NCH; j++) begin
                acc_q[j] <= '0;
            end
        end else begin
            ptr_q       <= ptr_d;
            out_valid_q <= out_valid_d;
            out_ch_q    <= out_ch_d;
            out_data_q  <= out_data_d;
            for (int j = 0; j < NCH; j++) begin
                acc_q[j] <= acc_d[j];
            end
        end
    end

    assign out_valid = out_valid_q;
    assign out_ch    = out_ch_q;
    assign out_data  = out_data_q;

endmodule
`default_nettype wire

// File: doc/integrator_rr_scheduler.md
# integrator_rr_scheduler

Time-shares one integrator adder among `NCH` requesting channels, keeping a per-channel accumulator bank. Each accepted sample is added to its channel's running sum, using the same two's-complement wrap-around arithmetic as the single-channel integrator datapath. Channels are served round-robin through valid/ready handshakes. Each update is emitted on a single backpressured result port tagged with the channel index. The block sits between the sample sources and the downstream consumer of integrated values.

## Interface

Parameters:
- `NCH`, 4: number of requesting channels (≥2).
- `W`, 10: sample and accumulator width, signed.
- `CW`, 2: channel index width, equal to clog2(`NCH`).

Ports:
- `system1000`, in, 1: clock. The block uses only this clock.
- `system1000_rstn`, in, 1: reset, synchronous and active-low.
- `req_valid`, in, `NCH`: per-channel sample valid.
- `req_data`, in, `NCH*W`: packed signed samples. Channel i occupies bits [i*W +: W].
- `req_ready`, out, `NCH`: per-channel accept. At most one bit is set (one-hot or zero).
- `clr`, in, `NCH`: per-channel accumulator clear, single-cycle pulse.
- `out_valid`, out, 1: result valid.
- `out_ch`, out, `CW`: channel index of the result.
- `out_data`, out, `W`: signed accumulator value after the update.
- `out_ready`, in, 1: downstream accept.

## Operation

- **State held by the block:**
  - `acc[0..NCH-1]`, W-bit signed accumulators.
  - `ptr`, a CW-bit round-robin pointer.
  - The output register: `out_valid`, `out_ch`, `out_data`.
- **Output stage free:** `free = !out_valid || out_ready`.
- **Arbitration (combinational):**
  - When `free` is high and rstn is high, grant the first i with `req_valid[i]`, searching ptr, ptr+1, …, wrapping mod NCH.
  - `req_ready[i] = 1` for that i only. Otherwise `req_ready` is all zero.
  - `req_ready` may depend combinationally on `req_valid` and `out_ready`.
- **Accept:** occurs when `req_valid[i] && req_ready[i]`. On accept:
  - `acc[i] <= base + sample_i`, truncated to W bits. This wraps; there is no saturation.
  - `out_valid <= 1`, `out_ch <= i`, `out_data <=` the same truncated sum.
  - `ptr <= (i+1) mod NCH`.
- **No accept:** `ptr` holds.
- **Output handshake:**
  - A result transfers when `out_valid && out_ready`.
  - If a transfer occurs and there is no accept in the same cycle, `out_valid <= 0`.
  - While `out_valid && !out_ready`, `out_ch` and `out_data` hold stable and `req_ready` is all zero.
  - `out_ready` is ignored while `out_valid = 0`.
- **Clear:**
  - `clr[j]` alone sets `acc[j] <= 0` next cycle and produces no output.
  - Clear takes precedence in ordering: if `clr[i]` coincides with an accept on channel i, `base = 0`, so the result equals the sample. Otherwise `base = acc[i]`.
  - Clears on several channels in the same cycle all take effect.
- **Reset** (rstn low at a rising edge):
  - `acc[*] = 0`, `ptr = 0`.
  - `out_valid = 0`, `out_ch = 0`, `out_data = 0`.
  - `req_ready` is forced to 0 while rstn is low.
  - A reset arriving mid-stream discards any pending result and all sums.

## Timing

- Latency: a sample accepted at edge k appears on `out_data` after edge k; it is valid in cycle k+1.
- Throughput: 1 sample per cycle aggregate when `out_ready` stays high. The output register re-loads in the same cycle it is drained.
- Fairness: with all channels continuously valid and no backpressure, grants follow 0, 1, …, NCH-1, 0, … Each channel waits at most NCH-1 cycles between grants.
- Backpressure: a stall freezes `ptr`. After release, the first grant goes to the next channel in round-robin order from the held `ptr`.
- First cycle after reset release: arbitration is enabled and the search starts at channel 0.

## Test plan

- **Reset:** hold rstn low 2 cycles with `req_valid = 4'hF` → `req_ready = 0` and `out_valid = 0`, `out_ch = 0`, `out_data = 0`. After release, channel 0 is granted first and its first result equals its first sample.
- **Single channel:** ch2 presents 3, 5, -2 on consecutive cycles, `out_ready = 1` → `req_ready[2] = 1` each cycle, `out_ch = 2`, `out_data = 3, 8, 6`, each one cycle after its accept.
- **Round-robin:** all channels valid with data 1, `out_ready = 1` → `out_ch` sequence 0, 1, 2, 3, 0, …; each channel's `out_data` increments by 1 every 4 cycles.
- **Backpressure:** drop `out_ready` for 3 cycles while `out_valid = 1` → `req_ready = 0`, and `out_ch`/`out_data` stay stable. On release, the result transfers and the next round-robin channel is accepted in the same cycle.
- **Wrap:** bring ch0 to 500, then add 20 → `out_data = -504`. From -500, add -30 → `out_data = 494`.
- **Clear:**
  - With `acc[1] = 7`, pulse `clr[1]` in the same cycle as accepting sample 4 on ch1 → `out_data = 4`.
  - `clr[3]` alone → no `out_valid`; the next ch3 sample of 2 gives `out_data = 2`.
